// File: rtl/pudding_chain_sequencer_if.sv
// Host-side bundle for the PUDDING chain sequencer.
// master: host bridge plus chain datapath (drives commands, write bytes, read
//         acceptance and the chain MSB).
// slave : the sequencer (drives handshake readies, read bytes, status and the
//         bit-serial chain controls).
interface pudding_chain_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic       abort;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       busy;
    logic       done;
    logic       chain_datum;
    logic       chain_shift;
    logic       chain_transfer;
    logic       chain_dir;
    logic       chain_msb;

    modport master (
        output cmd_valid, cmd_op, abort, in_valid, in_data, out_ready, chain_msb,
        input  cmd_ready, in_ready, out_valid, out_data, busy, done,
               chain_datum, chain_shift, chain_transfer, chain_dir
    );

    modport slave (
        input  cmd_valid, cmd_op, abort, in_valid, in_data, out_ready, chain_msb,
        output cmd_ready, in_ready, out_valid, out_data, busy, done,
               chain_datum, chain_shift, chain_transfer, chain_dir
    );
endinterface

// File: rtl/pudding_chain_sequencer.sv
// Sequencer for the PUDDING shift/state register pair. Converts byte-wide
// valid/ready streams and a command port into bit-serial chain controls.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of pudding_chain_sequencer_if
//              (cmd_*, abort, in_*, out_*, busy, done, chain_*)
//
// State | meaning
// IDLE  | waiting for a command, cmd_ready=1
// CAPT  | one-cycle transfer state->daisychain
// SHIFT | shifting CHAIN_LEN bits, stalling on empty input / full output
// APPLY | one-cycle transfer daisychain->state
// FLUSH | draining the last read byte(s) to the host
module pudding_chain_sequencer #(
    parameter int CHAIN_LEN = 256,
    parameter int CNT_W     = $clog2(CHAIN_LEN)
) (
    input  logic                    clk,
    input  logic                    rst,
    pudding_chain_sequencer_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_CAPT, S_SHIFT, S_APPLY, S_FLUSH} state_t;

    localparam logic [1:0] OP_LOAD     = 2'b00;
    localparam logic [1:0] OP_CAPTURE  = 2'b01;
    localparam logic [1:0] OP_EXCHANGE = 2'b10;
    localparam logic [1:0] OP_CLEAR    = 2'b11;
    localparam int NBYTES = CHAIN_LEN / 8;
    localparam int BYTE_W = $clog2(NBYTES + 1);

    state_t           state, state_nxt;
    logic [1:0]       op, op_nxt;
    logic [CNT_W-1:0] bit_cnt;
    logic [BYTE_W-1:0] byte_cnt;
    logic [7:0]       ib_data, ib_data_nxt;
    logic [3:0]       ib_cnt, ib_cnt_nxt;
    logic [7:0]       oa_data, oa_data_nxt;
    logic [3:0]       oa_cnt, oa_cnt_nxt;
    logic [7:0]       hold_data, hold_data_nxt;
    logic             hold_full, hold_full_nxt;
    logic             shift_r, transfer_r, dir_r, datum_r, done_r;
    logic             uses_in, uses_out, in_ready_c, in_take, out_take;
    logic             last_shift, shift_nxt, datum_nxt;

    assign bus.cmd_ready      = (state == S_IDLE);
    assign bus.busy           = (state != S_IDLE);
    assign bus.in_ready       = in_ready_c;
    assign bus.out_valid      = hold_full;
    assign bus.out_data       = hold_data;
    assign bus.done           = done_r;
    assign bus.chain_datum    = datum_r;
    assign bus.chain_shift    = shift_r;
    assign bus.chain_transfer = transfer_r;
    assign bus.chain_dir      = dir_r;

    // The chain controls are flops, so every decision about cycle N+1 is made
    // from the buffer contents that will be present after edge N. shift_r is
    // therefore both the chain strobe and the "a bit moves this cycle" flag.
    always_comb begin
        op_nxt = op;
        if (state == S_IDLE && bus.cmd_valid) begin
            op_nxt = bus.cmd_op;
        end
        uses_in  = (op_nxt == OP_LOAD) || (op_nxt == OP_EXCHANGE);
        uses_out = (op_nxt == OP_CAPTURE) || (op_nxt == OP_EXCHANGE);

        in_ready_c = (state == S_SHIFT) && uses_in && (byte_cnt < BYTE_W'(NBYTES)) &&
                     ((ib_cnt == 4'd0) || (ib_cnt == 4'd1 && shift_r));
        in_take    = in_ready_c && bus.in_valid;
        out_take   = hold_full && bus.out_ready;
        last_shift = shift_r && (bit_cnt == CNT_W'(CHAIN_LEN - 1));

        ib_data_nxt = ib_data;
        ib_cnt_nxt  = ib_cnt;
        if (shift_r && uses_in) begin
            ib_data_nxt = {ib_data[6:0], 1'b0};
            ib_cnt_nxt  = ib_cnt - 4'd1;
        end
        if (in_take) begin
            ib_data_nxt = bus.in_data;
            ib_cnt_nxt  = 4'd8;
        end

        // A completed byte waits in the assembler (oa_cnt == 8) until the
        // holding register frees up; shifting stalls meanwhile.
        oa_data_nxt   = oa_data;
        oa_cnt_nxt    = oa_cnt;
        hold_data_nxt = hold_data;
        hold_full_nxt = hold_full && !out_take;
        if (shift_r && uses_out) begin
            oa_data_nxt = {oa_data[6:0], bus.chain_msb};
            oa_cnt_nxt  = oa_cnt + 4'd1;
        end
        if (oa_cnt_nxt == 4'd8 && !hold_full_nxt) begin
            hold_data_nxt = oa_data_nxt;
            hold_full_nxt = 1'b1;
            oa_cnt_nxt    = 4'd0;
        end

        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    state_nxt = (bus.cmd_op == OP_CAPTURE || bus.cmd_op == OP_EXCHANGE) ?
                                S_CAPT : S_SHIFT;
                end
            end
            S_CAPT:  state_nxt = S_SHIFT;
            S_SHIFT: begin
                if (last_shift) begin
                    state_nxt = (op == OP_CAPTURE) ? S_FLUSH : S_APPLY;
                end
            end
            S_APPLY: state_nxt = (op == OP_EXCHANGE && hold_full_nxt) ? S_FLUSH : S_IDLE;
            S_FLUSH: begin
                if (!hold_full_nxt && oa_cnt_nxt == 4'd0) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        shift_nxt = (state_nxt == S_SHIFT) &&
                    (!uses_in || ib_cnt_nxt != 4'd0) &&
                    (!uses_out || oa_cnt_nxt < 4'd8);
        datum_nxt = shift_nxt && uses_in && ib_data_nxt[7];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            op         <= OP_LOAD;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            ib_data    <= '0;
            ib_cnt     <= '0;
            oa_data    <= '0;
            oa_cnt     <= '0;
            hold_data  <= '0;
            hold_full  <= 1'b0;
            shift_r    <= 1'b0;
            transfer_r <= 1'b0;
            dir_r      <= 1'b0;
            datum_r    <= 1'b0;
            done_r     <= 1'b0;
        end else if (bus.abort && state != S_IDLE) begin
            // No APPLY is issued, so the chain state register is left intact.
            state      <= S_IDLE;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            ib_data    <= '0;
            ib_cnt     <= '0;
            oa_data    <= '0;
            oa_cnt     <= '0;
            hold_full  <= 1'b0;
            shift_r    <= 1'b0;
            transfer_r <= 1'b0;
            dir_r      <= 1'b0;
            datum_r    <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state     <= state_nxt;
            op        <= op_nxt;
            ib_data   <= ib_data_nxt;
            ib_cnt    <= ib_cnt_nxt;
            oa_data   <= oa_data_nxt;
            oa_cnt    <= oa_cnt_nxt;
            hold_data <= hold_data_nxt;
            hold_full <= hold_full_nxt;
            if (state == S_IDLE && bus.cmd_valid) begin
                bit_cnt  <= '0;
                byte_cnt <= '0;
            end else begin
                if (shift_r) begin
                    bit_cnt <= last_shift ? '0 : bit_cnt + CNT_W'(1);
                end
                if (in_take) begin
                    byte_cnt <= byte_cnt + BYTE_W'(1);
                end
            end
            shift_r    <= shift_nxt;
            datum_r    <= datum_nxt;
            transfer_r <= (state_nxt == S_CAPT) || (state_nxt == S_APPLY);
            dir_r      <= (state_nxt == S_APPLY);
            done_r     <= (state != S_IDLE) && (state_nxt == S_IDLE);
        end
    end
endmodule

// File: tb/tb_pudding_chain_sequencer.sv
module tb_pudding_chain_sequencer;
    localparam int CHAIN_LEN = 256;
    localparam int NBYTES    = CHAIN_LEN / 8;
    localparam int BUDGET    = 5000;
    localparam logic [1:0] OP_LOAD     = 2'b00;
    localparam logic [1:0] OP_CAPTURE  = 2'b01;
    localparam logic [1:0] OP_EXCHANGE = 2'b10;
    localparam logic [1:0] OP_CLEAR    = 2'b11;

    // in_mode : 0 always valid, 1 random, 2 always valid incl. a 33rd byte
    // out_mode: 0 always ready, 1 one cycle in four, 2 random
    // data_kind: 0 incrementing, 1 0xA5, 2 random
    typedef struct {
        logic [1:0] op;
        int         in_mode;
        int         out_mode;
        int         data_kind;
        int         abort_bytes;
        int         abort_cyc;
        bit         stray;
        bit         check_lat;
        int         exp_apply;
        int         exp_done;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    logic [7:0]           mem_model [NBYTES];
    logic [CHAIN_LEN-1:0] daisy  = '0;
    logic [CHAIN_LEN-1:0] pstate = '0;

    pudding_chain_sequencer_if bus ();

    pudding_chain_sequencer #(.CHAIN_LEN(CHAIN_LEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Behavioural chain datapath: daisychain shifts left, state latches on transfer.
    assign bus.chain_msb = daisy[CHAIN_LEN-1];
    always @(posedge clk) begin
        if (bus.chain_shift) daisy <= {daisy[CHAIN_LEN-2:0], bus.chain_datum};
        if (bus.chain_transfer) begin
            if (bus.chain_dir) pstate <= daisy;
            else               daisy  <= pstate;
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [CHAIN_LEN-1:0] pack_mem();
        logic [CHAIN_LEN-1:0] v;
        for (int i = 0; i < NBYTES; i++) v[CHAIN_LEN-1-8*i -: 8] = mem_model[i];
        return v;
    endfunction

    task automatic check_idle(input string name);
        logic [16:0] got;
        got = {bus.cmd_ready, bus.busy, bus.in_ready, bus.out_valid, bus.out_data, bus.done,
               bus.chain_datum, bus.chain_shift, bus.chain_transfer, bus.chain_dir};
        chk(name, longint'(got), longint'(17'h10000));
    endtask

    task automatic run_op(input vec_t v, input string name);
        logic [7:0] wb [33];
        logic [7:0] rd [$];
        logic [7:0] prev_data;
        int  wptr, shifts, applies, capts, dones, overlap, datum_hi, stall_viol, rd_bad;
        int  first_sh, last_sh, apply_cyc, done_cyc, abort_seen, cyc;
        bit  aborted, finished, uses_in, uses_out, prev_hold, prev_abort;
        wptr = 0; shifts = 0; applies = 0; capts = 0; dones = 0; overlap = 0;
        datum_hi = 0; stall_viol = 0; first_sh = -1; last_sh = -1; apply_cyc = -1;
        done_cyc = -1; abort_seen = -1; aborted = 0; finished = 0;
        prev_hold = 0; prev_abort = 0; prev_data = '0;
        uses_in  = (v.op == OP_LOAD) || (v.op == OP_EXCHANGE);
        uses_out = (v.op == OP_CAPTURE) || (v.op == OP_EXCHANGE);
        for (int i = 0; i < 33; i++) begin
            case (v.data_kind)
                0:       wb[i] = 8'(i);
                1:       wb[i] = 8'hA5;
                default: wb[i] = 8'($urandom);
            endcase
        end

        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = v.op;
        #1;
        chk({name, " cmd_ready"}, longint'(bus.cmd_ready), 1);

        for (cyc = 0; cyc < BUDGET && !finished; cyc++) begin
            @(negedge clk);
            bus.cmd_valid = v.stray && bus.busy;
            bus.cmd_op    = v.op ^ 2'b11;
            if (v.in_mode == 2) bus.in_valid = (wptr < 33);
            else bus.in_valid = (wptr < NBYTES) && (v.in_mode == 0 || $urandom_range(1, 0) == 1);
            bus.in_data   = wb[(wptr < 33) ? wptr : 32];
            case (v.out_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = (cyc % 4 == 0);
                default: bus.out_ready = ($urandom_range(1, 0) == 1);
            endcase
            bus.abort = !aborted && ((v.abort_bytes >= 0 && wptr == v.abort_bytes) ||
                                     (v.abort_cyc == cyc));
            #1;
            if (prev_hold && !prev_abort && (!bus.out_valid || bus.out_data !== prev_data))
                stall_viol++;
            prev_hold  = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_abort = bus.abort;
            if (bus.in_valid && bus.in_ready) wptr++;
            if (bus.out_valid && bus.out_ready) rd.push_back(bus.out_data);
            if (bus.chain_shift) begin
                shifts++;
                if (first_sh < 0) first_sh = cyc;
                last_sh = cyc;
                if (bus.chain_datum) datum_hi++;
            end
            if (bus.chain_transfer) begin
                if (bus.chain_dir) begin applies++; apply_cyc = cyc; end
                else capts++;
            end
            if (bus.chain_shift && bus.chain_transfer) overlap++;
            if (bus.done) begin dones++; done_cyc = cyc; end
            if (aborted && cyc == abort_seen + 1)
                chk({name, " abort_to_idle"}, longint'(bus.cmd_ready), 1);
            if (!aborted && dones > 0 && cyc >= done_cyc + 3) finished = 1;
            if (aborted && cyc >= abort_seen + 4) finished = 1;
            if (bus.abort) begin aborted = 1; abort_seen = cyc; end
        end
        bus.abort = 1'b0; bus.cmd_valid = 1'b0; bus.in_valid = 1'b0;

        chk({name, " completed_in_budget"}, longint'(finished), 1);
        chk({name, " done_pulses"}, dones, v.exp_done);
        chk({name, " apply_transfers"}, applies, v.exp_apply);
        chk({name, " capture_transfers"}, capts, uses_out ? 1 : 0);
        chk({name, " shift_transfer_overlap"}, overlap, 0);
        chk({name, " out_data_stable"}, stall_viol, 0);
        if (!aborted) begin
            chk({name, " shift_count"}, shifts, CHAIN_LEN);
            chk({name, " bytes_accepted"}, wptr, uses_in ? NBYTES : 0);
            chk({name, " bytes_read"}, rd.size(), uses_out ? NBYTES : 0);
        end
        if (v.op == OP_CLEAR) chk({name, " clear_datum_ones"}, datum_hi, 0);
        if (v.check_lat) begin
            chk({name, " first_shift_cycle"}, first_sh, 1);
            chk({name, " last_shift_cycle"}, last_sh, CHAIN_LEN);
            chk({name, " apply_cycle"}, apply_cyc, CHAIN_LEN + 1);
            chk({name, " done_cycle"}, done_cyc, CHAIN_LEN + 2);
        end
        rd_bad = -1;
        for (int i = 0; i < rd.size() && i < NBYTES; i++)
            if (rd_bad < 0 && rd[i] !== mem_model[i]) rd_bad = i;
        checks++;
        if (rd_bad >= 0) begin
            errors++;
            $display("FAIL %s read_byte[%0d]: got %h expected %h", name, rd_bad,
                     rd[rd_bad], mem_model[rd_bad]);
        end

        if (!aborted) begin
            if (uses_in) for (int i = 0; i < NBYTES; i++) mem_model[i] = wb[i];
            if (v.op == OP_CLEAR) for (int i = 0; i < NBYTES; i++) mem_model[i] = 8'h00;
        end
        checks++;
        if (pstate !== pack_mem()) begin
            errors++;
            $display("FAIL %s chain_state: got %h expected %h", name, pstate, pack_mem());
        end
    endtask

    initial begin
        vec_t tbl [10];
        vec_t rv;
        bit   ab;
        bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.abort = 1'b0;
        bus.in_valid  = 1'b0; bus.in_data = 8'h00; bus.out_ready = 1'b0;
        for (int i = 0; i < NBYTES; i++) mem_model[i] = 8'h00;

        tbl[0] = '{OP_LOAD,     0, 0, 0, -1,  -1, 1'b0, 1'b1, 1, 1};
        tbl[1] = '{OP_CAPTURE,  0, 0, 0, -1,  -1, 1'b0, 1'b0, 0, 1};
        tbl[2] = '{OP_EXCHANGE, 0, 1, 1, -1,  -1, 1'b0, 1'b0, 1, 1};
        tbl[3] = '{OP_LOAD,     0, 0, 2, 10,  -1, 1'b0, 1'b0, 0, 0};
        tbl[4] = '{OP_CAPTURE,  0, 1, 0, -1,  -1, 1'b1, 1'b0, 0, 1};
        tbl[5] = '{OP_LOAD,     2, 0, 2, -1,  -1, 1'b0, 1'b0, 1, 1};
        tbl[6] = '{OP_EXCHANGE, 1, 2, 2, -1,  -1, 1'b1, 1'b0, 1, 1};
        tbl[7] = '{OP_CAPTURE,  0, 2, 0, -1,  -1, 1'b0, 1'b0, 0, 1};
        tbl[8] = '{OP_CLEAR,    0, 0, 0, -1,  -1, 1'b0, 1'b0, 1, 1};
        tbl[9] = '{OP_EXCHANGE, 0, 0, 2, -1, 100, 1'b0, 1'b0, 0, 0};

        repeat (3) @(negedge clk);
        #1;
        check_idle("reset_outputs");
        rst = 1'b0;
        @(negedge clk);
        #1;
        check_idle("idle_after_reset");

        for (int t = 0; t < 10; t++) run_op(tbl[t], $sformatf("vec%0d", t));

        // Asynchronous reset in the middle of a LOAD shift.
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = OP_LOAD;
        @(negedge clk);
        bus.cmd_valid = 1'b0; bus.in_valid = 1'b1; bus.in_data = 8'hFF;
        repeat (50) @(negedge clk);
        #1;
        chk("busy_before_reset", longint'(bus.busy), 1);
        #1;
        rst = 1'b1;
        #1;
        check_idle("async_reset_midshift");
        @(negedge clk);
        rst = 1'b0; bus.in_valid = 1'b0;
        rv = '{OP_CLEAR, 0, 0, 0, -1, -1, 1'b0, 1'b0, 1, 1};
        run_op(rv, "clear_after_reset");
        rv = '{OP_CAPTURE, 0, 0, 0, -1, -1, 1'b0, 1'b0, 0, 1};
        run_op(rv, "capture_after_clear");

        for (int r = 0; r < 12; r++) begin
            ab = ($urandom_range(3, 0) == 0);
            rv.op          = 2'($urandom_range(3, 0));
            rv.in_mode     = int'($urandom_range(2, 0));
            rv.out_mode    = int'($urandom_range(2, 0));
            rv.data_kind   = 2;
            rv.abort_bytes = -1;
            rv.abort_cyc   = ab ? int'($urandom_range(200, 0)) : -1;
            rv.stray       = ($urandom_range(1, 0) == 1);
            rv.check_lat   = 1'b0;
            rv.exp_apply   = (!ab && rv.op != OP_CAPTURE) ? 1 : 0;
            rv.exp_done    = ab ? 0 : 1;
            run_op(rv, $sformatf("rand%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
